// File: rtl/tim_copy_pkg.sv
// Shared types for the TIM word-copy engine: FSM state encoding and the
// architectural register bundle carried between cycles.
package tim_copy_wires;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT_R = 3'd2,
    WRITE  = 3'd3,
    WAIT_W = 3'd4,
    DONE   = 3'd5
  } state_t;

  // count is held at full 32-bit width so the struct stays independent of LEN_WIDTH
  typedef struct packed {
    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] count;
    logic [31:0] data;
  } regs_t;

endpackage

// File: rtl/tim_copy.sv
// Word-by-word memory copy engine driving a valid/ready tightly-coupled memory
// port; one read then one write per word, never more than one request in flight.
module tim_copy
  import tim_copy_wires::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic                 start,
  input  logic [31:0]          src_addr,
  input  logic [31:0]          dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_valid,
  output logic                 mem_instr,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ready
);

  regs_t regs_reg;
  regs_t regs_next;

  always_comb begin
    regs_next = regs_reg;
    busy      = (regs_reg.state != IDLE);
    done      = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;

    case (regs_reg.state)
      IDLE: begin
        if (start) begin
          regs_next.src   = {src_addr[31:2], 2'b00};
          regs_next.dst   = {dst_addr[31:2], 2'b00};
          regs_next.count = 32'(length);
          regs_next.state = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        mem_valid       = 1'b1;
        mem_addr        = regs_reg.src;
        regs_next.state = WAIT_R;
      end
      WAIT_R: begin
        if (mem_ready) begin
          regs_next.data  = mem_rdata;
          regs_next.state = WRITE;
        end
      end
      WRITE: begin
        mem_valid       = 1'b1;
        mem_wstrb       = 4'hF;
        mem_addr        = regs_reg.dst;
        mem_wdata       = regs_reg.data;
        regs_next.state = WAIT_W;
      end
      WAIT_W: begin
        if (mem_ready) begin
          regs_next.src   = regs_reg.src + 32'd4;
          regs_next.dst   = regs_reg.dst + 32'd4;
          regs_next.count = regs_reg.count - 32'd1;
          regs_next.state = (regs_reg.count == 32'd1) ? DONE : READ;
        end
      end
      DONE: begin
        done            = 1'b1;
        regs_next.state = IDLE;
      end
      default: regs_next.state = IDLE;
    endcase
  end

  // Clearing to IDLE also drops any response still owed to a pre-reset request.
  always_ff @(posedge clock) begin
    if (!reset) begin
      regs_reg <= '0;
    end else begin
      regs_reg <= regs_next;
    end
  end

endmodule

// File: tb/tb_tim_copy.sv
// Self-checking bench for tim_copy: memory responder with programmable latency,
// transaction-level copy model, directed corner cases and randomized copies.
module tb_tim_copy;

  localparam int LW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   src_addr = 32'h0;
  logic [31:0]   dst_addr = 32'h0;
  logic [LW-1:0] length = '0;
  logic          busy, done, mem_valid, mem_instr;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata = 32'h0;
  logic          mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  tim_copy #(.LEN_WIDTH(LW)) dut (
    .reset(reset), .clock(clock), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] rd_log[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  bit          mon_en = 1'b0;
  int          valid_count = 0;

  function automatic logic [31:0] seed_val(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] tim_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : seed_val(a);
  endfunction

  function automatic logic [31:0] model_rd(logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : seed_val(a);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory responder: answers each request resp_delay cycles after it is seen.
  int   resp_delay = 1;
  int   pend = 0;
  req_t pend_req;
  bit   cancel = 1'b0;

  always @(negedge clock) begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_ready = 1'b1;
        if (pend_req.wstrb == 4'h0)
          mem_rdata = cancel ? $urandom : tim_rd(pend_req.addr);
        else if (!cancel)
          mem[pend_req.addr] = pend_req.wdata;
        cancel = 1'b0;
      end
    end
    if (mon_en && mem_valid) begin
      check("one_outstanding", 32'(pend), 32'd0);
      pend     = resp_delay;
      pend_req = '{mem_addr, mem_wdata, mem_wstrb};
    end
  end

  // Per-cycle compare of the bus against the expected transaction stream.
  always @(negedge clock) begin
    if (mon_en) begin
      check("mem_instr", 32'(mem_instr), 32'd0);
      if (mem_valid) begin
        valid_count++;
        check("valid_while_busy", 32'(busy), 32'd1);
        if (mem_wstrb == 4'h0) rd_log.push_back(mem_addr);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_request actual=addr %h wstrb %h required=no request", mem_addr, mem_wstrb);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          check("req_addr", mem_addr, e.addr);
          check("req_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
          check("req_wdata", mem_wdata, e.wdata);
        end
      end else begin
        check("idle_addr", mem_addr, 32'h0);
        check("idle_wdata", mem_wdata, 32'h0);
        check("idle_wstrb", 32'(mem_wstrb), 32'h0);
      end
    end
  end

  // Copy semantics: word i is read from src+4i and written to dst+4i in order.
  task automatic build_expected(logic [31:0] s, logic [31:0] d, int n);
    logic [31:0] rs, ws, v;
    rs = {s[31:2], 2'b00};
    ws = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++) begin
      v = model_rd(rs + 32'(4 * i));
      exp_q.push_back('{rs + 32'(4 * i), 32'h0, 4'h0});
      exp_q.push_back('{ws + 32'(4 * i), v, 4'hF});
      model_mem[ws + 32'(4 * i)] = v;
    end
  endtask

  task automatic run_copy(string tag, logic [31:0] s, logic [31:0] d, int n, int dly,
                          bit mid_start, output int done_at);
    int k, busy_cnt, limit, exp_done;
    logic [31:0] ws;
    build_expected(s, d, n);
    resp_delay = dly;
    @(negedge clock);
    start = 1'b1; src_addr = s; dst_addr = d; length = LW'(n);
    @(negedge clock);
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom;
    k = 1; busy_cnt = 0; done_at = -1;
    limit = 2 * n * (1 + dly) + 20;
    while (k <= limit) begin
      if (done) begin
        done_at = k;
        break;
      end
      if (busy) busy_cnt++;
      start = 1'b0;
      if (mid_start && k == 3) begin
        start = 1'b1; src_addr = 32'h0000_0800; dst_addr = 32'h0000_0900; length = LW'(7);
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    exp_done = 2 * n * (1 + dly) + 1;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_done - 1));
    @(negedge clock);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
    check({tag, "_all_requests_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    ws = {d[31:2], 2'b00};
    for (int i = 0; i < n; i++)
      check({tag, "_dst_word"}, tim_rd(ws + 32'(4 * i)), model_rd(ws + 32'(4 * i)));
    $display("copy %s src=%h dst=%h len=%0d latency=%0d done_at=%0d", tag, s, d, n, dly, done_at);
  endtask

  initial begin
    int da, wcount, vc0;
    logic [31:0] v0;

    repeat (3) @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_valid", 32'(mem_valid), 32'd0);
    check("reset_addr", mem_addr, 32'h0);
    mon_en = 1'b1;
    reset = 1'b1;
    @(negedge clock);

    // Preloaded four-word copy with a one-cycle responder.
    for (int i = 0; i < 4; i++) begin
      mem[32'h100 + 32'(4 * i)]       = 32'(11 * (i + 1));
      model_mem[32'h100 + 32'(4 * i)] = 32'(11 * (i + 1));
    end
    run_copy("four_words", 32'h100, 32'h200, 4, 1, 1'b0, da);
    check("four_words_done_17", 32'(da), 32'd17);
    check("dst_200", tim_rd(32'h200), 32'd11);
    check("dst_204", tim_rd(32'h204), 32'd22);
    check("dst_208", tim_rd(32'h208), 32'd33);
    check("dst_20c", tim_rd(32'h20C), 32'd44);

    // Zero-length copy: no bus traffic, done one cycle after start.
    vc0 = valid_count;
    run_copy("zero_len", 32'h100, 32'h600, 0, 1, 1'b0, da);
    check("zero_len_done_1", 32'(da), 32'd1);
    check("zero_len_no_valid", 32'(valid_count - vc0), 32'd0);

    // Slow responder: ready arrives in the third cycle counting the request cycle.
    run_copy("slow_resp", 32'h100, 32'h280, 2, 2, 1'b0, da);
    check("slow_resp_done_13", 32'(da), 32'd13);
    check("slow_dst_280", tim_rd(32'h280), 32'd11);
    check("slow_dst_284", tim_rd(32'h284), 32'd22);

    // Address wrap and source alignment.
    rd_log.delete();
    run_copy("wrap", 32'hFFFF_FFFC, 32'h500, 2, 1, 1'b0, da);
    check("wrap_second_read", (rd_log.size() > 1) ? rd_log[1] : 32'hDEAD_BEEF, 32'h0);
    rd_log.delete();
    run_copy("align", 32'h103, 32'h540, 1, 1, 1'b0, da);
    check("align_first_read", (rd_log.size() > 0) ? rd_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Start pulse while busy must be ignored.
    run_copy("mid_start", 32'h100, 32'h700, 3, 1, 1'b1, da);

    // Reset during WAIT_W of word 2 of 4; its late ready must be ignored.
    v0 = model_rd(32'h300);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{32'h300 + 32'(4 * i), 32'h0, 4'h0});
      exp_q.push_back('{32'h400 + 32'(4 * i), model_rd(32'h300 + 32'(4 * i)), 4'hF});
    end
    model_mem[32'h400] = v0;
    resp_delay = 3;
    @(negedge clock);
    start = 1'b1; src_addr = 32'h300; dst_addr = 32'h400; length = LW'(4);
    @(negedge clock);
    start = 1'b0;
    wcount = 0;
    for (int k = 0; k < 60 && wcount < 2; k++) begin
      if (mem_valid && mem_wstrb != 4'h0) wcount++;
      if (wcount < 2) @(negedge clock);
    end
    check("reset_test_reached_word2", 32'(wcount), 32'd2);
    @(negedge clock);
    check("wait_w_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    cancel = 1'b1;
    @(negedge clock);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_valid", 32'(mem_valid), 32'd0);
    exp_q.delete();
    reset = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check("post_reset_busy", 32'(busy), 32'd0);
      check("post_reset_done", 32'(done), 32'd0);
    end
    check("partial_word1", tim_rd(32'h400), v0);
    check("partial_word2_unwritten", 32'(mem.exists(32'h404)), 32'd0);
    $display("copy reset_abort src=00000300 dst=00000400 len=4 aborted in word 2");

    // Randomized copies, including overlapping source and destination windows.
    for (int t = 0; t < 12; t++) begin
      logic [31:0] s, d;
      s = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      d = 32'h1080 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      run_copy("random", s, d, $urandom_range(0, 5), $urandom_range(1, 3), 1'($urandom_range(0, 1)), da);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tim_copy.md
TIM_COPY -- requirements
Module: tim_copy

Interface
REQ-001 SHALL have parameter LEN_WIDTH, default 16, word-count width of the length input.
REQ-002 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port start  input  1  one-cycle copy request.
REQ-005 SHALL have port src_addr  input  32  source byte address.
REQ-006 SHALL have port dst_addr  input  32  destination byte address.
REQ-007 SHALL have port length  input  LEN_WIDTH  number of 32-bit words to copy.
REQ-008 SHALL have port busy  output  1  copy in progress.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port mem_valid  output  1  request strobe to memory responder.
REQ-011 SHALL have port mem_instr  output  1  instruction-fetch flag, tied 0.
REQ-012 SHALL have port mem_addr  output  32  request byte address.
REQ-013 SHALL have port mem_wdata  output  32  write data.
REQ-014 SHALL have port mem_wstrb  output  4  byte strobes; 0 = read.
REQ-015 SHALL have port mem_rdata  input  32  read data, valid while mem_ready=1.
REQ-016 SHALL have port mem_ready  input  1  response strobe, latency >=1 cycle after mem_valid.

Function
REQ-017 SHALL implement states IDLE, READ, WAIT_R, WRITE, WAIT_W, DONE.
REQ-018 SHALL, in IDLE with start=1, latch src_addr, dst_addr (bits [1:0] forced 0) and length, and move to READ; length=0 moves straight to DONE with no bus traffic.
REQ-019 SHALL ignore start in every state except IDLE.
REQ-020 SHALL, in READ, drive mem_valid=1, mem_wstrb=0, mem_addr=current source for exactly one cycle, then go to WAIT_R.
REQ-021 SHALL, in WAIT_R with mem_ready=1, capture mem_rdata into a data register and go to WRITE; stay otherwise.
REQ-022 SHALL, in WRITE, drive mem_valid=1, mem_wstrb=4'hF, mem_addr=current destination, mem_wdata=captured data for exactly one cycle, then go to WAIT_W.
REQ-023 SHALL, in WAIT_W with mem_ready=1, add 4 to both addresses (modulo 2^32, wrap allowed), decrement remaining count, and go to DONE if count becomes 0, else READ.
REQ-024 SHALL ignore mem_ready and mem_rdata outside WAIT_R/WAIT_W.
REQ-025 SHALL drive done=1 for the single DONE cycle, then return to IDLE; a start in the cycle after DONE is accepted.
REQ-026 SHALL drive busy=1 in every state except IDLE.
REQ-027 SHALL drive mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0 in states other than READ/WRITE.
REQ-028 SHALL, with a 1-cycle-latency responder, issue the first read the cycle after start and assert done 4*N+1 cycles after the start cycle for N>0 words; done appears 1 cycle after start for N=0.
REQ-029 SHALL have at most one outstanding request at any time.

Reset
REQ-030 SHALL, on reset=0 at a rising edge, enter IDLE and clear all registers, including mid-copy; busy, done and all mem_* outputs read 0 the following cycle.
REQ-031 SHALL disregard any mem_ready arriving after reset for a request issued before reset.

Structure
REQ-032 SHALL place the state enum and register struct (state, src, dst, count, data) in package tim_copy_wires; LEN_WIDTH stays a module parameter.
REQ-033 SHALL be one module with a combinational next-state block and one registered always_ff; no sub-module.
REQ-034 SHALL be connectable directly to the tightly-coupled memory's valid/ready/addr/wdata/wstrb/rdata ports.

Verification
REQ-035 SHALL cover: TIM preloaded 0x100..0x10C = 11,22,33,44; start src=0x100 dst=0x200 len=4 -> 0x200..0x20C = 11,22,33,44, done at cycle 17 after start, busy 16 cycles.
REQ-036 SHALL cover: start with len=0 -> done 1 cycle later, mem_valid never 1.
REQ-037 SHALL cover: responder with 3-cycle ready latency, len=2 -> one request outstanding, data correct, done at cycle 13 after start.
REQ-038 SHALL cover: src=0xFFFFFFFC len=2 -> second read address 0x00000000; src=0x103 -> first read address 0x100.
REQ-039 SHALL cover: start pulsed while busy -> ignored; reset=0 during WAIT_W of word 2 of 4 -> IDLE next cycle, only word 1 written, late mem_ready ignored.
